// File: rtl/parameter_pkg.sv
// Shared width and depth parameters for the commit trace recorder.
package parameter_pkg;
    localparam int ADDR_WIDTH  = 32;
    localparam int ROB_WIDTH   = 6;
    localparam int PHY_WIDTH   = 7;
    localparam int TRACE_DEPTH = 16;
endpackage

// File: rtl/typedef_pkg.sv
// Trace record layout and kind bit positions.
// TRACE_CYCLE_STAMP_EN adds a 32-bit capture-cycle field to each record.
package typedef_pkg;
    import parameter_pkg::*;

    localparam int TRACE_KIND_PR     = 0;
    localparam int TRACE_KIND_STORE  = 1;
    localparam int TRACE_KIND_BRANCH = 2;

    typedef struct packed {
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0]           cycle;
`endif
        logic [2:0]            kind;
        logic [4:0]            rd_arch;
        logic [PHY_WIDTH-1:0]  phy_old;
        logic [PHY_WIDTH-1:0]  phy_new;
        logic [ROB_WIDTH-1:0]  rob_id;
        logic [ADDR_WIDTH-1:0] pc;
    } TRACE_RECORD_t;
endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with separate occupancy counter and synchronous clear.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-stage trace recorder: builds records on retire, queues them, counts drops.
// TRACE_CYCLE_STAMP_EN adds a free-running cycle stamp to each record.
module commit_trace_buffer
    import parameter_pkg::*;
    import typedef_pkg::*;
#(
    parameter int DEPTH           = TRACE_DEPTH,
    parameter int ADDR_WIDTH_P    = ADDR_WIDTH,
    parameter int ROB_WIDTH_P     = ROB_WIDTH,
    parameter int PHY_WIDTH_P     = PHY_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     retire_pr_valid,
    input  logic                     retire_store_valid,
    input  logic                     retire_branch_valid,
    input  logic [4:0]               rd_arch_commit,
    input  logic [PHY_WIDTH_P-1:0]   rd_phy_old_commit,
    input  logic [PHY_WIDTH_P-1:0]   rd_phy_new_commit,
    input  logic [ROB_WIDTH_P-1:0]   rob_id_commit,
    input  logic [ADDR_WIDTH_P-1:0]  pc_commit,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output TRACE_RECORD_t            trace_record,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic [15:0]              drop_count,
    output logic                     overflow
);
    logic          capture;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;
    TRACE_RECORD_t rec;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cycle_q;

    // Not affected by clear so stamps stay comparable across flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_q + 1'b1;
    end
`endif

    assign capture     = retire_pr_valid | retire_store_valid | retire_branch_valid;
    assign trace_valid = ~empty;
    assign pop         = trace_valid & trace_ready;
    assign push        = capture & ~clear;
    assign drop        = capture & full & ~pop & ~clear;

    always_comb begin
        rec = '0;
        rec.kind[TRACE_KIND_PR]     = retire_pr_valid;
        rec.kind[TRACE_KIND_STORE]  = retire_store_valid;
        rec.kind[TRACE_KIND_BRANCH] = retire_branch_valid;
        if (retire_pr_valid) begin
            rec.rd_arch = rd_arch_commit;
            rec.phy_old = rd_phy_old_commit;
            rec.phy_new = rd_phy_new_commit;
        end
        rec.rob_id = rob_id_commit;
        rec.pc     = pc_commit;
`ifdef TRACE_CYCLE_STAMP_EN
        rec.cycle  = cycle_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            overflow <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH ($bits(TRACE_RECORD_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (rec),
        .rdata (trace_record),
        .full  (full),
        .empty (empty),
        .count (trace_count)
    );
endmodule
